// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Bus-mapped 8N1 UART transmitter with TX FIFO and programmable
//            bit period; combinational reads, clocked writes.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx
);
    localparam int unsigned        c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned        c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]        c_DIV_RST    = 16'(CLK_DIV);
    localparam logic [1:0]         c_OFF_TXDATA = 2'd0;
    localparam logic [1:0]         c_OFF_STATUS = 2'd1;
    localparam logic [1:0]         c_OFF_DIV    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [15:0]        r_div;
    state_t             r_state;
    logic [15:0]        r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic       w_sel;
    logic [1:0] w_off;
    logic       w_wr;
    logic       w_push_req;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_bit_done;
    logic       w_busy;
    logic       w_unused;

    assign w_sel      = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = addr[3:2];
    assign w_wr       = w_sel && we;
    assign w_push_req = w_wr && (w_off == c_OFF_TXDATA);
    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    // Acceptance looks only at the pre-edge count, so a same-cycle pop never frees room.
    assign w_push     = w_push_req && !w_full;
    assign w_bit_done = (r_bit_cnt == 16'd0);
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_busy     = (r_state != S_IDLE);
    assign w_unused   = ^{addr[1:0], data_i[31:16]};
    assign tx         = r_tx;

    always_comb begin
        data_o = 32'd0;
        if (w_sel) begin
            case (w_off)
                c_OFF_STATUS: data_o = {17'd0, 7'(r_count), 4'd0, r_overflow, w_busy, w_empty, w_full};
                c_OFF_DIV:    data_o = {16'd0, r_div};
                default:      data_o = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_div      <= c_DIV_RST;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_off == c_OFF_STATUS) && data_i[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (w_off == c_OFF_DIV) && (data_i[15:0] != 16'd0)) begin
                r_div <= data_i[15:0];
            end
        end
    end

    // Every bit period reloads the counter from the live divisor at its first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_bit_cnt <= r_div - 16'd1;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_bit_cnt <= r_div - 16'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= r_div - 16'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (w_pop) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_state   <= S_START;
                            r_tx      <= 1'b0;
                            r_bit_cnt <= r_div - 16'd1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Self-checking bench for mmio_uart_tx with a frame-decoding monitor
//            and a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    localparam logic [31:0] c_BASE   = 32'h0000_1000;
    localparam logic [31:0] c_TXDATA = c_BASE + 32'h0;
    localparam logic [31:0] c_STATUS = c_BASE + 32'h4;
    localparam logic [31:0] c_DIVREG = c_BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  sb[$];
    int          f_start[$];
    int          f_end[$];
    bit          mon_en = 1'b1;
    bit          mon_busy = 1'b0;
    int unsigned mon_div = 16;

    mmio_uart_tx #(
        .BASE_ADDR (c_BASE),
        .CLK_DIV   (16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .we    (we),
        .addr  (addr),
        .data_i(data_i),
        .data_o(data_o),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 d = data_o;
        @(posedge clk);
        #1;
        ce = 1'b0; addr = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        if (accept) sb.push_back(b);
        bus_write(c_TXDATA, {24'd0, b});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", {31'd0, n >= limit}, 32'd0);
    endtask

    task automatic wait_idle(input int limit);
        logic [31:0] s;
        int n = 0;
        do begin
            bus_read(c_STATUS, s);
            n++;
        end while (s[2] && n < limit);
        check_eq("idle_timeout", {31'd0, s[2]}, 32'd0);
    endtask

    // Decodes one 8N1 frame per start bit at the current bench divisor.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                logic [9:0] bits;
                bit stable;
                bit aborted;
                int t0;
                mon_busy = 1'b1; stable = 1'b1; aborted = 1'b0; t0 = cyc; bits = '0;
                for (int i = 0; i < int'(10 * mon_div); i++) begin
                    if (i > 0) @(negedge clk);
                    if (!mon_en || !rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % int'(mon_div) == 0) bits[i / int'(mon_div)] = tx;
                    else if (tx !== bits[i / int'(mon_div)]) stable = 1'b0;
                end
                if (!aborted) begin
                    check_eq("frame_shape", {31'd0, stable & ~bits[0] & bits[9]}, 32'd1);
                    check_eq("frame_pending", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) check_eq("frame_byte", {24'd0, bits[8:1]}, {24'd0, sb.pop_front()});
                    f_start.push_back(t0);
                    f_end.push_back(cyc);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic test_reset_and_div0();
        logic [31:0] r;
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        bus_read(c_STATUS, r);  check_eq("rst_status", r, 32'h0000_0002);
        bus_read(c_DIVREG, r);  check_eq("rst_div", r, 32'd16);
        bus_read(c_TXDATA, r);  check_eq("rd_txdata", r, 32'd0);
        bus_read(c_BASE + 32'hC, r); check_eq("rd_unmapped", r, 32'd0);
        bus_write(c_DIVREG, 32'd0);
        bus_read(c_DIVREG, r);  check_eq("div_zero_ignored", r, 32'd16);
    endtask

    task automatic test_single();
        logic [31:0] r;
        int busy_cnt = 0;
        bus_write(c_DIVREG, 32'd4);
        mon_div = 4;
        push_byte(8'h55, 1'b1);
        ce = 1'b1; we = 1'b0; addr = c_STATUS;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq("lat_pre_tx", {31'd0, tx}, 32'd1);
                check_eq("lat_count", {25'd0, data_o[14:8]}, 32'd1);
            end
            if (i == 1) check_eq("lat_start_tx", {31'd0, tx}, 32'd0);
            if (data_o[2]) busy_cnt++;
        end
        ce = 1'b0; addr = '0;
        check_eq("busy_cycles", busy_cnt, 32'd40);
        drain(200);
        bus_read(c_STATUS, r);  check_eq("single_status", r, 32'h0000_0002);
    endtask

    task automatic test_b2b();
        int base;
        bus_write(c_DIVREG, 32'd2);
        mon_div = 2;
        base = f_start.size();
        push_byte(8'hA3, 1'b1);
        push_byte(8'h0F, 1'b1);
        push_byte(8'hFF, 1'b1);
        drain(400);
        check_eq("b2b_frames", f_start.size() - base, 32'd3);
        if (f_start.size() - base == 3) begin
            check_eq("b2b_gap1", f_start[base + 1] - f_end[base], 32'd1);
            check_eq("b2b_gap2", f_start[base + 2] - f_end[base + 1], 32'd1);
            check_eq("b2b_span", f_end[base + 2] - f_start[base] + 1, 32'd60);
        end
        wait_idle(20);
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus_write(c_DIVREG, 32'd100);
        mon_div = 100;
        for (int i = 0; i < 10; i++) push_byte(8'(i), i < 9);
        bus_read(c_STATUS, r);  check_eq("ovf_status", r, 32'h0000_080D);
        bus_write(c_STATUS, 32'h8);
        bus_read(c_STATUS, r);  check_eq("ovf_cleared", r, 32'h0000_0805);
        drain(12000);
        wait_idle(20);
    endtask

    task automatic test_div_midframe();
        int runs[9];
        mon_en = 1'b0;
        foreach (runs[j]) runs[j] = 0;
        bus_write(c_DIVREG, 32'd8);
        push_byte(8'h55, 1'b0);
        fork
            begin
                int run;
                int nruns;
                int guard;
                logic cur;
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (tx !== 1'b0 && guard < 50);
                cur = 1'b0; run = 1; nruns = 0;
                while (nruns < 9 && guard < 300) begin
                    @(negedge clk);
                    guard++;
                    if (tx === cur) run++;
                    else begin
                        runs[nruns] = run;
                        nruns++;
                        cur = tx;
                        run = 1;
                    end
                end
            end
            begin
                repeat (3) @(posedge clk);
                bus_write(c_DIVREG, 32'd3);
            end
        join
        check_eq("div_old_bit", runs[0], 32'd8);
        for (int j = 1; j < 9; j++) check_eq("div_new_bit", runs[j], 32'd3);
        wait_idle(50);
        mon_en = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] r;
        bus_write(c_BASE + 32'h10, 32'h77);
        bus_write(32'h0000_0000, 32'h77);
        bus_read(c_STATUS, r);  check_eq("decode_status", r, 32'h0000_0002);
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = c_STATUS;
        #1 check_eq("decode_ce0", data_o, 32'd0);
        ce = 1'b1; addr = 32'h0000_2004;
        #1 check_eq("decode_other", data_o, 32'd0);
        ce = 1'b0; addr = '0;
        check_eq("decode_tx", {31'd0, tx}, 32'd1);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int lows = 0;
        mon_en = 1'b0;
        bus_write(c_DIVREG, 32'd4);
        push_byte(8'h00, 1'b0);
        push_byte(8'h34, 1'b0);
        push_byte(8'h56, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_tx", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1 check_eq("rst_async_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus_read(c_STATUS, r);  check_eq("post_rst_status", r, 32'h0000_0002);
        bus_read(c_DIVREG, r);  check_eq("post_rst_div", r, 32'd16);
        sb.delete();
        mon_div = 16;
        mon_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("post_rst_quiet", lows, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset_and_div0();
        test_single();
        test_b2b();
        test_overflow();
        test_div_midframe();
        test_decode();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
